wb_burst_ram_slave: RTL and testbench

Wishbone B4 slave holding an on-chip RAM, with registered-feedback burst support.
- Sits directly downstream of wishbone_bus on one slave port. Consumes that port's s_adr/s_dat/s_sel/s_we/s_cyc/s_stb/s_cti/s_bte outputs and returns dat/ack/err/rty.
- Supports classic cycles and CTI incrementing bursts, with linear or wrap-4/8/16 BTE address sequencing.
- Sustains one beat per cycle inside a burst.

---
 rtl/wb_pkg.sv | 30 +++
 rtl/wb_burst_addr_gen.sv | 32 +++
 rtl/wb_burst_ram_slave.sv | 136 +++++++++++++
 tb/tb_wb_burst_ram_slave.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone B4 definitions: cycle-type and burst-type codes, the
// slave FSM state type and a constant-friendly log2 helper.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_BEAT
  } state_e;

  // Smallest r such that 2**r >= value (usable in localparam expressions).
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Next-beat word address for Wishbone incrementing bursts. Linear bursts
// roll over the whole RAM; wrap-4/8/16 bursts increment only the low
// 2/3/4 bits and hold the rest. Purely combinational.
module wb_burst_addr_gen
  import wb_pkg::*;
#(
  parameter int AW   = 10,
  parameter int BTEw = 2
) (
  input  logic [AW-1:0]   addr_i,
  input  logic [BTEw-1:0] bte_i,
  output logic [AW-1:0]   addr_nxt_o
);

  logic [AW-1:0] wrap_mask;
  logic [AW-1:0] addr_inc;

  // Bits under wrap_mask take the incremented value, the rest are held.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    wrap_mask = '1;
    case (bte_i)
      BTE_WRAP4:  wrap_mask = AW'(4'h3);
      BTE_WRAP8:  wrap_mask = AW'(4'h7);
      BTE_WRAP16: wrap_mask = AW'(4'hF);
      default:    wrap_mask = '1;
    endcase
    addr_inc   = addr_i + AW'(1);
    addr_nxt_o = (addr_i & ~wrap_mask) | (addr_inc & wrap_mask);
  end

endmodule

// File: rtl/wb_burst_ram_slave.sv
// Wishbone B4 slave wrapping an on-chip RAM with registered-feedback
// incrementing bursts (linear, wrap-4/8/16) at one beat per cycle.
// Classic cycles take two clocks. Optional macro WB_RAM_ERR_EN turns
// accesses with address bits above the RAM range into a single err beat;
// without it those bits are ignored and sa_err_o stays 0.
module wb_burst_ram_slave
  import wb_pkg::*;
#(
  parameter int Dw     = 32,
  parameter int Aw     = 32,
  parameter int SELw   = 4,
  parameter int CTIw   = 3,
  parameter int BTEw   = 2,
  parameter int RAM_AW = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Aw-1:0]   sa_adr_i,
  input  logic [Dw-1:0]   sa_dat_i,
  input  logic [SELw-1:0] sa_sel_i,
  input  logic            sa_we_i,
  input  logic            sa_cyc_i,
  input  logic            sa_stb_i,
  input  logic [CTIw-1:0] sa_cti_i,
  input  logic [BTEw-1:0] sa_bte_i,
  output logic [Dw-1:0]   sa_dat_o,
  output logic            sa_ack_o,
  output logic            sa_err_o,
  output logic            sa_rty_o
);

  localparam int AOFF  = log2(SELw);
  localparam int DEPTH = 1 << RAM_AW;

  logic [Dw-1:0]     mem [DEPTH];
  state_e            state_q, state_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [RAM_AW-1:0] baddr_q, baddr_d;
  logic [RAM_AW-1:0] baddr_nxt;
  logic [RAM_AW-1:0] raddr;
  logic [RAM_AW-1:0] waddr;
  logic [Dw-1:0]     dat_q;
  logic              req;
  logic              burst_go;
  logic              wr_en;
  logic              adr_hi;
  logic              unused_adr;

  assign req      = sa_cyc_i & sa_stb_i;
  assign waddr    = sa_adr_i[RAM_AW+AOFF-1:AOFF];
  assign burst_go = req & (sa_cti_i == CTI_INC);
  // Byte-offset bits never address anything; upper bits only matter with the error check.
  assign unused_adr = ^sa_adr_i;

`ifdef WB_RAM_ERR_EN
  assign adr_hi = |(sa_adr_i >> (RAM_AW + AOFF));
`else
  // Upper address bits alias onto the RAM, so err_q can never set.
  assign adr_hi = 1'b0;
`endif

  // Gating with req keeps a dropped cyc/stb from seeing a stray ack or err.
  assign sa_ack_o = ack_q & req;
  assign sa_err_o = err_q & req;
  assign sa_rty_o = 1'b0;
  assign sa_dat_o = dat_q;
  assign wr_en    = sa_ack_o & sa_we_i;

  wb_burst_addr_gen #(
    .AW   (RAM_AW),
    .BTEw (BTEw)
  ) u_addr_gen (
    .addr_i     (baddr_q),
    .bte_i      (sa_bte_i),
    .addr_nxt_o (baddr_nxt)
  );

  // Next-state logic; the RAM read address looks one beat ahead so that
  // read data is already registered when the beat's ack is presented.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    err_d   = err_q;
    baddr_d = baddr_q;
    raddr   = waddr;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_BEAT;
          baddr_d = waddr;
          ack_d   = ~adr_hi;
          err_d   = adr_hi;
        end
      end
      ST_BEAT: begin
        raddr = baddr_nxt;
        if (burst_go && ack_q) begin
          baddr_d = baddr_nxt;
        end else begin
          // Classic, end-of-burst, reserved cti, dropped request or err beat.
          state_d = ST_IDLE;
          ack_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
    endcase
  end

  // Control state and registered read data, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      baddr_q <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      baddr_q <= baddr_d;
      dat_q   <= mem[raddr];
    end
  end

  // Byte-lane writes into the RAM array.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset; clearing it would prevent block-RAM mapping.
    for (int i = 0; i < SELw; i++) begin
      if (wr_en && sa_sel_i[i]) mem[baddr_q][i*8 +: 8] <= sa_dat_i[i*8 +: 8];
    end
  end

endmodule

// File: tb/tb_wb_burst_ram_slave.sv
// Self-checking bench for wb_burst_ram_slave: directed scenarios followed
// by random bursts, all checked against a word-array model of the RAM and
// the cycle-exact ack timing of the slave.
module tb_wb_burst_ram_slave;
  import wb_pkg::*;

  localparam int WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;
  logic        rty;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] model [WORDS];

  wb_burst_ram_slave dut (
    .clk      (clk),
    .reset    (reset),
    .sa_adr_i (adr),
    .sa_dat_i (dat_w),
    .sa_sel_i (sel),
    .sa_we_i  (we),
    .sa_cyc_i (cyc),
    .sa_stb_i (stb),
    .sa_cti_i (cti),
    .sa_bte_i (bte),
    .sa_dat_o (dat_r),
    .sa_ack_o (ack),
    .sa_err_o (err),
    .sa_rty_o (rty)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Burst address sequence: wrap bursts stay inside an aligned block of len words.
  function automatic int next_word(input int a, input logic [1:0] b);
    int len;
    case (b)
      2'b01:   len = 4;
      2'b10:   len = 8;
      2'b11:   len = 16;
      default: len = WORDS;
    endcase
    return (a - (a % len)) + ((a + 1) % len);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input bit exp_ack, input bit exp_err, input string tag);
    @(negedge clk);
    check({tag, "/ack"}, 32'(ack), 32'(exp_ack));
    check({tag, "/err"}, 32'(err), 32'(exp_err));
    check({tag, "/rty"}, 32'(rty), 32'h0);
  endtask

  task automatic go_idle();
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    sample(1'b0, 1'b0, "idle");
    next_cycle();
  endtask

  // One master transaction of n beats. Entered just after a rising edge;
  // leaves the last beat's request asserted so a following call runs back
  // to back. Aborts (drops cyc/stb) once stop_after beats have completed.
  task automatic run_burst(input bit wr, input int word, input logic [1:0] b, input int n,
                           input int stop_after, input logic [2:0] last_cti,
                           input logic [3:0] fix_sel, input bit fix_dat,
                           input logic [31:0] dat0, input logic [31:0] adr_hi,
                           input string tag);
    int          a;
    logic [31:0] d;
    logic [3:0]  s;
    a = word;
    for (int k = 0; k < n; k++) begin
      if (k == stop_after) begin
        cyc = 1'b0;
        stb = 1'b0;
        sample(1'b0, 1'b0, {tag, "/abort"});
        next_cycle();
        return;
      end
      d     = fix_dat ? dat0 + 32'(k) : $urandom;
      s     = (fix_sel != 4'h0) ? fix_sel : 4'($urandom_range(1, 15));
      adr   = adr_hi | (32'(a) << 2) | 32'($urandom_range(0, 3));
      dat_w = wr ? d : $urandom;
      sel   = s;
      we    = wr;
      cti   = (k == n - 1) ? last_cti : CTI_INC;
      bte   = b;
      cyc   = 1'b1;
      stb   = 1'b1;
      if (k == 0) begin
        sample(1'b0, 1'b0, {tag, "/first"});
        next_cycle();
      end
      sample(1'b1, 1'b0, {tag, "/beat"});
      if (!wr) check({tag, "/rdat"}, dat_r, model[a]);
      next_cycle();
      if (wr) begin
        for (int i = 0; i < 4; i++) begin
          if (s[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
        end
      end
      a = next_word(a, b);
    end
  endtask

  logic [2:0] last_cti_tab [4];
  bit         r_wr;
  logic [1:0] r_bte;
  int         r_len;
  int         r_word;

  initial begin
    last_cti_tab[0] = CTI_CLASSIC;
    last_cti_tab[1] = CTI_END;
    last_cti_tab[2] = CTI_CONST;
    last_cti_tab[3] = 3'b101;

    // Reset state, with a request already pending on the bus.
    reset = 1'b1;
    adr = '0; dat_w = '0; sel = '0; we = 1'b0;
    cyc = 1'b1; stb = 1'b1; cti = CTI_CLASSIC; bte = BTE_LINEAR;
    repeat (2) @(negedge clk);
    check("rst/ack", 32'(ack), 32'h0);
    check("rst/err", 32'(err), 32'h0);
    check("rst/rty", 32'(rty), 32'h0);
    check("rst/dat", dat_r, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 1'b0;
    stb = 1'b0;
    sample(1'b0, 1'b0, "post_rst");
    next_cycle();

    // Give every RAM word a known value.
    for (int blk = 0; blk < WORDS / 16; blk++) begin
      run_burst(1'b1, blk * 16, BTE_LINEAR, 16, -1, CTI_END, 4'hF, 1'b0, 32'h0, 32'h0, "fill");
    end
    go_idle();

    // Classic write then back-to-back classic read of address 0x10.
    run_burst(1'b1, 4, BTE_LINEAR, 1, -1, CTI_CLASSIC, 4'hF, 1'b1, 32'hDEAD_BEEF, 32'h0, "t1_wr");
    run_burst(1'b0, 4, BTE_LINEAR, 1, -1, CTI_CLASSIC, 4'hF, 1'b0, 32'h0, 32'h0, "t1_rd");
    go_idle();

    // Single byte lane over the same word.
    run_burst(1'b1, 4, BTE_LINEAR, 1, -1, CTI_CLASSIC, 4'b0001, 1'b1, 32'h0000_00AA, 32'h0, "t2_wr");
    run_burst(1'b0, 4, BTE_LINEAR, 1, -1, CTI_CLASSIC, 4'hF, 1'b0, 32'h0, 32'h0, "t2_rd");
    go_idle();

    // Linear 4-beat write of 1..4 at word 0, linear read back, then wrap-4 from word 2.
    run_burst(1'b1, 0, BTE_LINEAR, 4, -1, CTI_END, 4'hF, 1'b1, 32'h1, 32'h0, "t3_wr");
    run_burst(1'b0, 0, BTE_LINEAR, 4, -1, CTI_END, 4'hF, 1'b0, 32'h0, 32'h0, "t3_rd");
    run_burst(1'b0, 2, BTE_WRAP4, 4, -1, CTI_END, 4'hF, 1'b0, 32'h0, 32'h0, "t4_wrap4");
    go_idle();

    // 8-beat write abandoned after two beats; words 0,1 change, word 2 does not.
    run_burst(1'b1, 0, BTE_LINEAR, 8, 2, CTI_END, 4'hF, 1'b1, 32'h100, 32'h0, "t5_wr");
    for (int w = 0; w < 3; w++) begin
      run_burst(1'b0, w, BTE_LINEAR, 1, -1, CTI_CLASSIC, 4'hF, 1'b0, 32'h0, 32'h0, "t5_rd");
    end
    go_idle();

    // Access with address bits above the RAM range.
`ifdef WB_RAM_ERR_EN
    adr = 32'h0000_1000; dat_w = 32'hA5A5_0000; sel = 4'hF; we = 1'b1;
    cti = CTI_CLASSIC; bte = BTE_LINEAR; cyc = 1'b1; stb = 1'b1;
    sample(1'b0, 1'b0, "t6_err_first");
    next_cycle();
    sample(1'b0, 1'b1, "t6_err");
    next_cycle();
    go_idle();
    run_burst(1'b0, 0, BTE_LINEAR, 1, -1, CTI_CLASSIC, 4'hF, 1'b0, 32'h0, 32'h0, "t6_rd");
`else
    run_burst(1'b1, 0, BTE_LINEAR, 1, -1, CTI_CLASSIC, 4'hF, 1'b1, 32'hA5A5_0000, 32'h0000_1000, "t6_alias_wr");
    run_burst(1'b0, 0, BTE_LINEAR, 1, -1, CTI_CLASSIC, 4'hF, 1'b0, 32'h0, 32'h0, "t6_alias_rd");
`endif
    go_idle();

    // Reset while a write beat is acked but not yet completed: the write is lost.
    adr = 32'(8) << 2; dat_w = 32'h5555_AAAA; sel = 4'hF; we = 1'b1;
    cti = CTI_INC; bte = BTE_LINEAR; cyc = 1'b1; stb = 1'b1;
    sample(1'b0, 1'b0, "t7_first");
    next_cycle();
    sample(1'b1, 1'b0, "t7_beat");
    #1;
    reset = 1'b1;
    #1;
    check("t7_rst/ack", 32'(ack), 32'h0);
    check("t7_rst/dat", dat_r, 32'h0);
    next_cycle();
    reset = 1'b0;
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    sample(1'b0, 1'b0, "t7_after");
    next_cycle();
    run_burst(1'b0, 8, BTE_LINEAR, 1, -1, CTI_CLASSIC, 4'hF, 1'b0, 32'h0, 32'h0, "t7_rd");
    go_idle();

    // Random bursts of every kind against the model.
    for (int it = 0; it < 80; it++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_bte  = 2'($urandom_range(0, 3));
      r_len  = (r_bte == BTE_LINEAR) ? $urandom_range(1, 20) : $urandom_range(1, 2 << r_bte);
      r_word = $urandom_range(0, WORDS - 1);
      run_burst(r_wr, r_word, r_bte, r_len, -1, last_cti_tab[$urandom_range(0, 3)],
                4'h0, 1'b0, 32'h0, 32'h0, "rnd");
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
